// File: rtl/freq_div_ctrl.sv
// freq_div_ctrl: run-time clock divider with glitch-free ratio updates and start/stop gating
module freq_div_ctrl #(
    parameter int CNT_W       = 16,
    parameter int DEFAULT_DIV = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             cfg_valid,
    input  logic [CNT_W-1:0] cfg_div,
    output logic             cfg_ready,
    output logic             cfg_err,
    output logic             clk_out,
    output logic             tick,
    output logic             running,
    output logic [CNT_W-1:0] div_act
);
    typedef enum logic {STOP, RUN} state_t;

    localparam logic [CNT_W-1:0] ONE_N = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W:0]   ONE_W = {{CNT_W{1'b0}}, 1'b1};

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] div_act_q, div_act_d;
    logic [CNT_W-1:0] div_pend_q, div_pend_d;
    logic             pend_q, pend_d;
    logic             clk_out_q, clk_out_d;
    logic             tick_q, tick_d;
    logic             cfg_err_q, cfg_err_d;
    logic [CNT_W:0]   hi, cnt_inc;
    logic             xfer, legal, wrap;

    // hi and cnt+1 carry one extra bit so the maximum ratio cannot overflow
    assign hi      = ({1'b0, div_act_q} + ONE_W) >> 1;
    assign cnt_inc = {1'b0, cnt_q} + ONE_W;
    assign wrap    = cnt_q == div_act_q - ONE_N;
    assign legal   = |cfg_div[CNT_W-1:1];
    assign xfer    = cfg_valid && cfg_ready;

    assign cfg_err = cfg_err_q;
    assign clk_out = clk_out_q;
    assign tick    = tick_q;
    assign div_act = div_act_q;

    // State and datapath registers; reset drops clk_out without waiting for an edge
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= STOP;
            cnt_q      <= '0;
            div_act_q  <= CNT_W'(DEFAULT_DIV);
            div_pend_q <= '0;
            pend_q     <= 1'b0;
            clk_out_q  <= 1'b0;
            tick_q     <= 1'b0;
            cfg_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            div_act_q  <= div_act_d;
            div_pend_q <= div_pend_d;
            pend_q     <= pend_d;
            clk_out_q  <= clk_out_d;
            tick_q     <= tick_d;
            cfg_err_q  <= cfg_err_d;
        end
    end

    // Next state: en is only looked at while stopped or on the last cycle of a period
    always_comb begin
        state_d = state_q;
        if (state_q == STOP)
            state_d = en ? RUN : STOP;
        else if (wrap && !en)
            state_d = STOP;
    end

    // Counter, ratio bookkeeping and registered clock/strobe for the next cycle
    always_comb begin
        cnt_d      = cnt_q;
        div_act_d  = div_act_q;
        div_pend_d = div_pend_q;
        pend_d     = pend_q;
        clk_out_d  = 1'b0;
        tick_d     = 1'b0;
        cfg_err_d  = xfer && !legal;
        if (state_q == STOP) begin
            if (xfer && legal)
                div_act_d = cfg_div;
            cnt_d     = '0;
            clk_out_d = en;
            tick_d    = en;
        end else begin
            if (xfer && legal) begin
                div_pend_d = cfg_div;
                pend_d     = 1'b1;
            end
            if (wrap) begin
                cnt_d = '0;
                if (pend_q) begin
                    div_act_d = div_pend_q;
                    pend_d    = 1'b0;
                end
                clk_out_d = en;
                tick_d    = en;
            end else begin
                cnt_d     = cnt_q + ONE_N;
                clk_out_d = cnt_inc < hi;
            end
        end
    end

    // Status outputs decoded from state; a new ratio can always be taken while stopped
    always_comb begin
        running   = state_q == RUN;
        cfg_ready = (state_q == STOP) || !pend_q;
    end
endmodule

// File: tb/tb_freq_div_ctrl.sv
// tb_freq_div_ctrl: directed checks of divide patterns, ratio handshake, stop and async reset
module tb_freq_div_ctrl;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en = 1'b0;
    logic        cfg_valid = 1'b0;
    logic [15:0] cfg_div = '0;
    logic        cfg_ready, cfg_err, clk_out, tick, running;
    logic [15:0] div_act;
    int          n_tests = 0;
    int          n_fail = 0;

    freq_div_ctrl #(.CNT_W(16), .DEFAULT_DIV(4)) dut (
        .clk(clk), .rst(rst), .en(en), .cfg_valid(cfg_valid), .cfg_div(cfg_div),
        .cfg_ready(cfg_ready), .cfg_err(cfg_err), .clk_out(clk_out), .tick(tick),
        .running(running), .div_act(div_act)
    );

    always #10 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // n: ratio, start: counter value after the first edge, cycles: edges to check
    task automatic chk_run(input string tag, input int n, input int start, input int cycles);
        for (int i = 0; i < cycles; i++) begin
            int c;
            step();
            c = (start + i) % n;
            check({tag, "_clk"}, clk_out, c < (n + 1) / 2);
            check({tag, "_tick"}, tick, c == 0);
            check({tag, "_run"}, running, 1);
        end
    endtask

    initial begin
        // reset state
        #25;
        check("rst_clk", clk_out, 0);
        check("rst_tick", tick, 0);
        check("rst_err", cfg_err, 0);
        check("rst_run", running, 0);
        check("rst_div", div_act, 4);
        check("rst_rdy", cfg_ready, 1);
        rst = 1'b0;
        step();
        check("stop_clk", clk_out, 0);
        check("stop_run", running, 0);

        // N=4 run: 1,1,0,0 with tick on each rise
        en = 1'b1;
        chk_run("n4", 4, 0, 8);

        // mid-period update to 6 at cnt=1
        chk_run("n4b", 4, 0, 2);
        check("upd_rdy0", cfg_ready, 1);
        cfg_valid = 1'b1;
        cfg_div = 16'd6;
        step();
        check("upd_c2_clk", clk_out, 0);
        check("upd_c2_rdy", cfg_ready, 0);
        check("upd_c2_div", div_act, 4);
        cfg_div = 16'd7;
        step();
        check("upd_c3_clk", clk_out, 0);
        check("upd_c3_rdy", cfg_ready, 0);
        step();
        check("upd_wrap_div", div_act, 6);
        check("upd_wrap_clk", clk_out, 1);
        check("upd_wrap_tick", tick, 1);
        check("upd_wrap_rdy", cfg_ready, 1);
        cfg_valid = 1'b0;
        chk_run("n6", 6, 1, 11);
        check("n6_div", div_act, 6);

        // illegal ratios 1 and 0 at N=6, starting at cnt=5
        cfg_valid = 1'b1;
        cfg_div = 16'd1;
        step();
        check("ill1_err", cfg_err, 1);
        check("ill1_clk", clk_out, 1);
        check("ill1_div", div_act, 6);
        cfg_valid = 1'b0;
        step();
        check("ill1_err_off", cfg_err, 0);
        check("ill1_c1_clk", clk_out, 1);
        cfg_valid = 1'b1;
        cfg_div = 16'd0;
        step();
        check("ill0_err", cfg_err, 1);
        check("ill0_clk", clk_out, 1);
        check("ill0_rdy", cfg_ready, 1);
        cfg_valid = 1'b0;
        step();
        check("ill0_err_off", cfg_err, 0);
        check("ill0_c3_clk", clk_out, 0);
        check("ill0_div", div_act, 6);
        chk_run("n6b", 6, 4, 8);

        // stop on the last cycle of the period
        en = 1'b0;
        step();
        check("stp_run", running, 0);
        check("stp_clk", clk_out, 0);
        check("stp_tick", tick, 0);
        step();
        check("stp2_clk", clk_out, 0);

        // odd N=5 configured while stopped
        cfg_valid = 1'b1;
        cfg_div = 16'd5;
        check("n5_rdy", cfg_ready, 1);
        step();
        cfg_valid = 1'b0;
        check("n5_div", div_act, 5);
        check("n5_run", running, 0);
        check("n5_clk", clk_out, 0);
        en = 1'b1;
        chk_run("n5", 5, 0, 10);

        // transfer on the wrap cycle: one more full period at 5, then 4
        cfg_valid = 1'b1;
        cfg_div = 16'd4;
        step();
        cfg_valid = 1'b0;
        check("wr_div", div_act, 5);
        check("wr_rdy", cfg_ready, 0);
        check("wr_clk", clk_out, 1);
        chk_run("wr5", 5, 1, 4);
        chk_run("wr4", 4, 0, 1);
        check("wr4_div", div_act, 4);
        chk_run("wr4b", 4, 1, 4);

        // stop at cnt=1 with N=4: two low cycles then STOP
        chk_run("s4", 4, 1, 1);
        en = 1'b0;
        step();
        check("s_c2_clk", clk_out, 0);
        check("s_c2_run", running, 1);
        step();
        check("s_c3_clk", clk_out, 0);
        check("s_c3_run", running, 1);
        step();
        check("s_end_run", running, 0);
        check("s_end_clk", clk_out, 0);
        check("s_end_tick", tick, 0);

        // restart, queue a ratio, then async reset mid-period
        en = 1'b1;
        chk_run("rs", 4, 0, 2);
        cfg_valid = 1'b1;
        cfg_div = 16'd9;
        step();
        cfg_valid = 1'b0;
        check("rs_rdy", cfg_ready, 0);
        #5 rst = 1'b1;
        #1;
        check("ar_clk", clk_out, 0);
        check("ar_run", running, 0);
        check("ar_div", div_act, 4);
        check("ar_rdy", cfg_ready, 1);
        en = 1'b0;
        #3 rst = 1'b0;
        step();
        en = 1'b1;
        chk_run("post", 4, 0, 8);
        check("post_div", div_act, 4);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
